// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU issue controller: FSM states,
// condition-code encodings and the bit positions of the {Z,C,N,O} flag nibble.
package alu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        EVAL = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [3:0] COND_AL = 4'd0;
    localparam logic [3:0] COND_EQ = 4'd1;
    localparam logic [3:0] COND_NE = 4'd2;
    localparam logic [3:0] COND_CS = 4'd3;
    localparam logic [3:0] COND_CC = 4'd4;
    localparam logic [3:0] COND_MI = 4'd5;
    localparam logic [3:0] COND_PL = 4'd6;
    localparam logic [3:0] COND_VS = 4'd7;
    localparam logic [3:0] COND_VC = 4'd8;
    localparam logic [3:0] COND_HI = 4'd9;
    localparam logic [3:0] COND_LS = 4'd10;
    localparam logic [3:0] COND_GE = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GT = 4'd13;
    localparam logic [3:0] COND_LE = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

endpackage

// File: rtl/alu_cond_eval.sv
// Purpose: evaluates a 4-bit condition code against the {Z,C,N,O} flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; no handshake, output follows inputs.
module alu_cond_eval
    import alu_ctrl_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [3:0] cond,
    output logic       taken
);

    logic z;
    logic c;
    logic n;
    logic o;
    logic ge;

    assign z  = flags[FLAG_Z];
    assign c  = flags[FLAG_C];
    assign n  = flags[FLAG_N];
    assign o  = flags[FLAG_O];
    assign ge = (n == o);

    always_comb begin
        taken = 1'b0;
        case (cond)
            COND_AL: taken = 1'b1;
            COND_EQ: taken = z;
            COND_NE: taken = ~z;
            COND_CS: taken = c;
            COND_CC: taken = ~c;
            COND_MI: taken = n;
            COND_PL: taken = ~n;
            COND_VS: taken = o;
            COND_VC: taken = ~o;
            COND_HI: taken = c & ~z;
            COND_LS: taken = ~c | z;
            COND_GE: taken = ge;
            COND_LT: taken = ~ge;
            COND_GT: taken = ~z & ge;
            COND_LE: taken = z | ~ge;
            COND_NV: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_issue_controller.sv
// Purpose: issues one macro-op to the ALU, iterating N times through ALUOut, then reports result/flags/cond.
// Latency: accept at edge 0, EXEC edges 1..N, EVAL edge N+1, resp_valid from the cycle after.
// Backpressure: response held stable until resp_ready; req_ready low for the whole transaction.
module alu_issue_controller
    import alu_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             Clock,
    input  logic             Reset,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_funsel,
    input  logic             req_wf,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [CNT_W-1:0] req_count,
    input  logic [3:0]       req_cond,

    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    output logic [4:0]       ALU_FunSel,
    output logic             ALU_WF,
    input  logic [WIDTH-1:0] ALUOut,
    input  logic [3:0]       FlagsOut,

    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic [3:0]       resp_flags,
    output logic             resp_cond
);

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [3:0]       cond_q;
    logic             cond_taken;

    // Flags are evaluated as the ALU presents them in EVAL, one cycle after the last flag write.
    alu_cond_eval u_cond_eval (
        .flags (FlagsOut),
        .cond  (cond_q),
        .taken (cond_taken)
    );

    // ALU_A doubles as the accumulator, so the operand the ALU sees is always the live value.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= IDLE;
            remaining   <= '0;
            cond_q      <= '0;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_result <= '0;
            resp_flags  <= '0;
            resp_cond   <= 1'b0;
            ALU_A       <= '0;
            ALU_B       <= '0;
            ALU_FunSel  <= '0;
            ALU_WF      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        ALU_A      <= req_a;
                        ALU_B      <= req_b;
                        ALU_FunSel <= req_funsel;
                        ALU_WF     <= req_wf;
                        cond_q     <= req_cond;
                        remaining  <= (req_count == '0) ? CNT_W'(1) : req_count;
                        req_ready  <= 1'b0;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    ALU_A     <= ALUOut;
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        ALU_FunSel <= '0;
                        ALU_WF     <= 1'b0;
                        state      <= EVAL;
                    end
                end
                EVAL: begin
                    resp_result <= ALU_A;
                    resp_flags  <= FlagsOut;
                    resp_cond   <= cond_taken;
                    resp_valid  <= 1'b1;
                    state       <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_controller.sv
// Bench for alu_issue_controller with a behavioural ALU attached; a scoreboard of
// reference results is filled by the stimulus and drained by an independent monitor.
module tb_alu_issue_controller;
    import alu_ctrl_pkg::*;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    logic             Clock = 1'b0;
    logic             Reset = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [4:0]       req_funsel = '0;
    logic             req_wf = 1'b0;
    logic [WIDTH-1:0] req_a = '0;
    logic [WIDTH-1:0] req_b = '0;
    logic [CNT_W-1:0] req_count = '0;
    logic [3:0]       req_cond = '0;
    logic [WIDTH-1:0] ALU_A;
    logic [WIDTH-1:0] ALU_B;
    logic [4:0]       ALU_FunSel;
    logic             ALU_WF;
    logic [WIDTH-1:0] ALUOut;
    logic [3:0]       FlagsOut;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [WIDTH-1:0] resp_result;
    logic [3:0]       resp_flags;
    logic             resp_cond;

    always #5 Clock = ~Clock;

    alu_issue_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .Clock(Clock), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_funsel(req_funsel),
        .req_wf(req_wf), .req_a(req_a), .req_b(req_b), .req_count(req_count),
        .req_cond(req_cond),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
        .ALUOut(ALUOut), .FlagsOut(FlagsOut),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
        .resp_flags(resp_flags), .resp_cond(resp_cond)
    );

    logic [3:0] ce_flags = '0;
    logic [3:0] ce_cond = '0;
    logic       ce_taken;

    alu_cond_eval u_ce (.flags(ce_flags), .cond(ce_cond), .taken(ce_taken));

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Behavioural ALU: 16 ops, bit4 selects 32-bit (1) or 16-bit (0) width; flags {Z,C,N,O}.
    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  f;
    } alu_res_t;

    function automatic alu_res_t alu_eval(input logic [4:0] fs, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] fin);
        alu_res_t    res;
        logic [32:0] aa, bb, t;
        logic [31:0] mask;
        int          msb;
        logic        cy, ov;
        msb  = fs[4] ? 31 : 15;
        mask = fs[4] ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        aa   = {1'b0, a & mask};
        bb   = {1'b0, b & mask};
        cy   = fin[2];
        ov   = fin[0];
        case (fs[3:0])
            4'd0:  t = aa;
            4'd1:  t = bb;
            4'd2:  t = {1'b0, ~a & mask};
            4'd3:  t = {1'b0, ~b & mask};
            4'd4, 4'd5: begin
                t  = aa + bb + ((fs[3:0] == 4'd5) ? {32'b0, fin[2]} : 33'd0);
                cy = t[msb+1];
                ov = (aa[msb] == bb[msb]) && (t[msb] != aa[msb]);
            end
            4'd6: begin
                t  = aa + {1'b0, ~b & mask} + 33'd1;
                cy = t[msb+1];
                ov = (aa[msb] != bb[msb]) && (t[msb] != aa[msb]);
            end
            4'd7:  t = aa & bb;
            4'd8:  t = aa | bb;
            4'd9:  t = aa ^ bb;
            4'd10: t = {1'b0, ~(a & b) & mask};
            4'd11: begin cy = aa[msb]; t = aa << 1; end
            4'd12: begin cy = aa[0];   t = aa >> 1; end
            4'd13: begin cy = aa[0];   t = (aa >> 1) | ({32'b0, aa[msb]} << msb); end
            4'd14: begin cy = aa[msb]; t = (aa << 1) | {32'b0, fin[2]}; end
            default: begin cy = aa[0]; t = (aa >> 1) | ({32'b0, fin[2]} << msb); end
        endcase
        res.r = t[31:0] & mask;
        res.f = {res.r == 32'h0, cy, res.r[msb], ov};
        return res;
    endfunction

    // Condition table grouped as predicate pairs: odd code = predicate, even code = its inverse.
    function automatic logic cond_ref(input logic [3:0] cc, input logic [3:0] f);
        logic z, c, n, o, p;
        int   g;
        z = f[3]; c = f[2]; n = f[1]; o = f[0];
        g = (int'(cc) + 1) / 2;
        case (g)
            1:       p = z;
            2:       p = c;
            3:       p = n;
            4:       p = o;
            5:       p = c & ~z;
            6:       p = (n == o);
            7:       p = ~z & (n == o);
            default: p = 1'b0;
        endcase
        return cc[0] ? p : ~p;
    endfunction

    logic [3:0] alu_flags = 4'h0;
    alu_res_t   alu_now;

    assign alu_now  = alu_eval(ALU_FunSel, ALU_A, ALU_B, alu_flags);
    assign ALUOut   = alu_now.r;
    assign FlagsOut = alu_flags;

    always @(posedge Clock) if (ALU_WF) alu_flags <= alu_now.f;

    typedef struct {
        int          acc_cyc;
        int          n;
        logic [4:0]  fs;
        logic        wf;
        logic [31:0] b;
        logic [31:0] ops [32];
        logic [31:0] result;
        logic [3:0]  flags;
        logic        cond;
        logic        dir;
        logic [31:0] dres;
        logic        dcond;
    } exp_t;

    exp_t       sb[$];
    exp_t       me;
    logic [3:0] model_flags = 4'h0;
    logic       abort = 1'b0;
    logic       bp_mode = 1'b0;
    int         bp_seen = 0;

    task automatic finish_now(input string why);
        errors++;
        checks++;
        $display("FAIL %s: bound expired at cycle %0d", why, cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "bench aborted");
    endtask

    // Called at a negedge; returns at the negedge following the accept edge.
    task automatic issue(input logic [4:0] fs, input logic wf, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] cnt, input logic [3:0] cc,
                         input logic dir, input logic [31:0] dres, input logic dcond);
        exp_t        e;
        logic [31:0] acc;
        logic [3:0]  fl;
        alu_res_t    r;
        int          w;
        e.n  = (cnt == 5'd0) ? 1 : int'(cnt);
        acc  = a;
        fl   = model_flags;
        for (int i = 0; i < e.n; i++) begin
            e.ops[i] = acc;
            r   = alu_eval(fs, acc, b, fl);
            acc = r.r;
            if (wf) fl = r.f;
        end
        model_flags = fl;
        e.fs = fs; e.wf = wf; e.b = b;
        e.result = acc; e.flags = fl; e.cond = cond_ref(cc, fl);
        e.dir = dir; e.dres = dres; e.dcond = dcond;
        req_funsel = fs; req_wf = wf; req_a = a; req_b = b; req_count = cnt; req_cond = cc;
        req_valid  = 1'b1;
        w = 0;
        while (!req_ready && w < 300) begin
            @(negedge Clock);
            w++;
        end
        if (!req_ready) finish_now("req_ready_wait");
        e.acc_cyc = cyc + 1;
        sb.push_back(e);
        @(negedge Clock);
        req_valid = 1'b0;
        req_a     = $urandom;
        req_count = 5'($urandom);
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((sb.size() != 0 || !req_ready) && w < 500) begin
            @(negedge Clock);
            w++;
        end
        if (sb.size() != 0 || !req_ready) finish_now("drain_wait");
    endtask

    always @(posedge Clock) begin
        #2;
        if (!bp_mode) begin
            resp_ready = ($urandom_range(0, 3) != 0);
        end else if (resp_valid) begin
            resp_ready = (bp_seen >= 3);
            bp_seen++;
        end else begin
            resp_ready = 1'b0;
            bp_seen    = 0;
        end
    end

    logic        prev_valid = 1'b0;
    logic [31:0] prev_res;
    logic [3:0]  prev_fl;
    logic        prev_cond;
    logic        popped = 1'b0;
    int          first_cyc = 0;
    int          k;

    always @(negedge Clock) begin
        if (Reset || abort) begin
            prev_valid = 1'b0;
            popped     = 1'b0;
        end else begin
            if (popped) begin
                chk("idle_after_handshake", {resp_valid, req_ready}, 2'b01);
                popped = 1'b0;
            end
            if (sb.size() > 0 && !resp_valid) begin
                me = sb[0];
                k  = cyc - me.acc_cyc;
                if (k >= 0 && k < me.n) begin
                    chk($sformatf("exec_alu_a[%0d]", k), ALU_A, me.ops[k]);
                    chk("exec_alu_b", ALU_B, me.b);
                    chk("exec_funsel", ALU_FunSel, me.fs);
                    chk("exec_wf", ALU_WF, me.wf);
                end else if (k >= me.n) begin
                    chk("eval_wf_low", ALU_WF, 1'b0);
                    chk("eval_funsel_zero", ALU_FunSel, 5'd0);
                end
            end
            if (resp_valid) begin
                chk("resp_req_ready_low", req_ready, 1'b0);
                chk("resp_wf_low", ALU_WF, 1'b0);
                if (!prev_valid) begin
                    first_cyc = cyc;
                end else begin
                    chk("hold_result", resp_result, prev_res);
                    chk("hold_flags", resp_flags, prev_fl);
                    chk("hold_cond", resp_cond, prev_cond);
                end
                prev_res  = resp_result;
                prev_fl   = resp_flags;
                prev_cond = resp_cond;
                if (resp_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_response", 1'b1, 1'b0);
                    end else begin
                        me = sb.pop_front();
                        chk("resp_result", resp_result, me.result);
                        chk("resp_flags", resp_flags, me.flags);
                        chk("resp_cond", resp_cond, me.cond);
                        chk("resp_latency", 64'(first_cyc - me.acc_cyc), 64'(me.n + 1));
                        if (me.dir) begin
                            chk("directed_result", resp_result, me.dres);
                            chk("directed_cond", resp_cond, me.dcond);
                        end
                        if (bp_mode) chk("bp_stall_cycles", 64'(cyc - first_cyc), 64'd3);
                    end
                    popped     = 1'b1;
                    prev_valid = 1'b0;
                end else begin
                    prev_valid = 1'b1;
                end
            end else begin
                prev_valid = 1'b0;
            end
        end
    end

    initial begin
        logic [4:0] fs;
        logic [4:0] cnt;
        repeat (3) @(posedge Clock);
        @(negedge Clock);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_resp_valid", resp_valid, 1'b0);
        chk("rst_resp_result", resp_result, 32'h0);
        chk("rst_resp_flags", resp_flags, 4'h0);
        chk("rst_resp_cond", resp_cond, 1'b0);
        chk("rst_alu_a", ALU_A, 32'h0);
        chk("rst_alu_b", ALU_B, 32'h0);
        chk("rst_alu_funsel", ALU_FunSel, 5'h0);
        chk("rst_alu_wf", ALU_WF, 1'b0);
        Reset = 1'b0;
        @(negedge Clock);

        for (int i = 0; i < 256; i++) begin
            ce_flags = 4'(i >> 4);
            ce_cond  = 4'(i);
            #1;
            chk($sformatf("cond_eval f=%0h c=%0d", ce_flags, ce_cond), ce_taken,
                cond_ref(ce_cond, ce_flags));
        end
        @(negedge Clock);

        // ADD 0xFFFFFFFF + 1 wraps to zero with Z set.
        issue(5'b10100, 1'b1, 32'hFFFF_FFFF, 32'h1, 5'd1, COND_EQ, 1'b1, 32'h0, 1'b1);
        wait_idle();
        // LSR four times: 0x80 -> 0x08.
        issue(5'b11100, 1'b1, 32'h80, 32'h0, 5'd4, COND_AL, 1'b1, 32'h8, 1'b1);
        wait_idle();
        // 5 - 7 is negative without overflow: LT taken, GE not.
        issue(5'b10110, 1'b1, 32'd5, 32'd7, 5'd1, COND_LT, 1'b1, 32'hFFFF_FFFE, 1'b1);
        issue(5'b10110, 1'b1, 32'd5, 32'd7, 5'd1, COND_GE, 1'b1, 32'hFFFF_FFFE, 1'b0);
        // Z set by 3-3, then XOR without flag write still sees Z=1.
        issue(5'b10110, 1'b1, 32'd3, 32'd3, 5'd1, COND_EQ, 1'b1, 32'h0, 1'b1);
        issue(5'b11001, 1'b0, 32'd3, 32'd3, 5'd1, COND_NE, 1'b1, 32'h0, 1'b0);
        wait_idle();

        bp_mode = 1'b1;
        issue(5'b10100, 1'b1, 32'h1111_0000, 32'h0000_2222, 5'd2, COND_PL, 1'b1,
              32'h1111_4444, 1'b1);
        wait_idle();
        bp_mode = 1'b0;

        issue(5'b10100, 1'b0, 32'h0000_0100, 32'h1, 5'd8, COND_AL, 1'b0, 32'h0, 1'b0);
        repeat (2) @(negedge Clock);
        abort = 1'b1;
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        sb.delete();
        chk("abort_req_ready", req_ready, 1'b1);
        chk("abort_resp_valid", resp_valid, 1'b0);
        chk("abort_alu_wf", ALU_WF, 1'b0);
        chk("abort_alu_a", ALU_A, 32'h0);
        abort = 1'b0;
        issue(5'b10100, 1'b1, 32'h0000_1234, 32'h0000_0010, 5'd0, COND_AL, 1'b1,
              32'h0000_1244, 1'b1);
        wait_idle();

        for (int t = 0; t < 60; t++) begin
            fs  = 5'($urandom);
            cnt = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            issue(fs, 1'($urandom), $urandom, $urandom, cnt, 4'($urandom), 1'b0, 32'h0, 1'b0);
        end
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_controller.md
Name: alu_issue_controller

Overview:
- Sits on the controller side of the ArithmeticLogicUnit interface.
- Accepts one ALU macro-operation per valid/ready handshake, then drives A, B, FunSel and WF into the ALU.
- Iterates shift/rotate ops N times by feeding ALUOut back into A, waits for the registered flags, and evaluates a condition code against them.
- Returns result, flags and condition outcome on a valid/ready response port; used by the control unit for compare-and-branch and multi-bit shifts.

Parameters:
- WIDTH, 32, ALU operand/result width.
- CNT_W, 5, width of the repeat-count field (max 31 iterations).

Ports:
- Clock  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller idle and able to accept.
- req_funsel  in  5  FunSel passed to ALU; bit4 = 32-bit width select.
- req_wf  in  1  flag-write enable for every ALU issue of this request.
- req_a  in  WIDTH  operand A (initial accumulator).
- req_b  in  WIDTH  operand B (held constant for all iterations).
- req_count  in  CNT_W  iteration count; 0 treated as 1.
- req_cond  in  4  condition code evaluated after the last iteration.
- ALU_A  out  WIDTH  to ALU A.
- ALU_B  out  WIDTH  to ALU B.
- ALU_FunSel  out  5  to ALU FunSel.
- ALU_WF  out  1  to ALU WF.
- ALUOut  in  WIDTH  combinational ALU result.
- FlagsOut  in  4  registered ALU flags {Z,C,N,O} = bits [3:0].
- resp_valid  out  1  response present.
- resp_ready  in  1  consumer accepts response.
- resp_result  out  WIDTH  final accumulator.
- resp_flags  out  4  FlagsOut snapshot {Z,C,N,O}.
- resp_cond  out  1  condition outcome.

Behaviour:
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_result=0, resp_flags=0, resp_cond=0, ALU_A=ALU_B=0, ALU_FunSel=0, ALU_WF=0.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready, latch funsel, wf, b, cond; acc<=req_a; remaining<=max(req_count,1); go to EXEC.
- EXEC:
  - ALU_A=acc, ALU_B=b_q, ALU_FunSel=funsel_q, ALU_WF=wf_q.
  - Each edge: acc<=ALUOut, remaining<=remaining-1.
  - When remaining==1 at the edge, go to EVAL.
  - Count applies to every op; for non-shift ops count>1 simply re-applies the op to the new accumulator.
- EVAL (one cycle):
  - ALU_WF=0, ALU_FunSel=0. FlagsOut now reflects the last EXEC edge.
  - Register resp_result<=acc, resp_flags<=FlagsOut, resp_cond<=cond(FlagsOut); go to RESP.
- RESP:
  - resp_valid=1; outputs held stable until resp_ready.
  - On resp_valid&resp_ready, go to IDLE with resp_valid=0 next cycle.
  - req_ready=0 throughout; no overlap of request and response.
- Latency: accept at edge 0, EXEC edges 1..N, EVAL edge N+1, resp_valid high from cycle N+2.
- ALU_WF is asserted only in EXEC, never outside it. With req_wf=0, flags are not updated and the condition is evaluated on the prior flags.
- Condition codes:
  - 0 AL=1, 1 EQ=Z, 2 NE=~Z, 3 CS=C, 4 CC=~C, 5 MI=N, 6 PL=~N, 7 VS=O, 8 VC=~O.
  - 9 HI=C&~Z, 10 LS=~C|Z, 11 GE=(N==O), 12 LT=(N!=O), 13 GT=~Z&(N==O), 14 LE=Z|(N!=O), 15 NV=0.
- Reset asserted in any state: next state IDLE, transaction discarded, all outputs return to reset values.
- req_valid while not in IDLE is ignored; the requester must hold it.

Decomposition:
- Shared package alu_ctrl_pkg holds:
  - state enum {IDLE, EXEC, EVAL, RESP};
  - condition-code constants COND_AL..COND_NV;
  - flag bit indices FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_O=0.
- One sub-module, alu_cond_eval: combinational, flags[3:0] + cond[3:0] -> taken. Unit-tested exhaustively (256 cases).

Test Plan (bench instantiates the real ArithmeticLogicUnit):
- ADD funsel=5'b10100, wf=1, A=0xFFFFFFFF, B=1, count=1, cond=EQ -> resp_result=0, resp_flags[3]=1, resp_cond=1, resp_valid on cycle 3.
- LSR funsel=5'b11100, A=0x00000080, count=4, cond=AL -> ALU_A sequence 0x80,0x40,0x20,0x10 on EXEC cycles; resp_result=0x00000008; resp_valid on cycle 6.
- SUB A=5, B=7, wf=1, cond=LT, then same with cond=GE -> first resp_cond=1, second resp_cond=0.
- Prior op sets Z=1, then XOR with wf=0, A=B=3... cond=NE -> ALU_WF never high, resp_flags unchanged, resp_cond=0.
- Backpressure: resp_ready=0 for 3 cycles -> resp_valid, resp_result and resp_flags stable; req_ready=0; handshake on cycle 4 returns to IDLE next cycle.
- Reset pulse mid-EXEC of count=8 -> next cycle: req_ready=1, resp_valid=0, ALU_WF=0; new request with count=0 completes as one iteration.
